// File: rtl/rxr_to_noc_basic_if.sv
// avalonST: receiver-side Avalon-ST packet stream.
//   data  : payload beat
//   valid : beat present (source -> sink)
//   ready : sink can take a beat (sink -> source)
//   sop   : first beat of a packet
//   eop   : last beat of a packet
//   empty : unused bytes in the eop beat
// Modports: snk (consumer side), src (producer side).
interface avalonST #(
    parameter int DATA_WIDTH = 512,
    parameter int EMPTY_W    = 6
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_W-1:0]    empty;

    modport snk (input data, valid, sop, eop, empty, output ready);
    modport src (output data, valid, sop, eop, empty, input ready);
endinterface

// File: rtl/rxr_to_noc_basic.sv
// rxr_to_noc_basic: Avalon-ST ingress to NoC flit bridge.
// Every accepted beat becomes one NoC flit holding payload, empty,
// head/tail, VC and destination. Destination and VC are captured on the
// sop beat and reused for the rest of the packet. A two-entry elastic
// buffer sits between the Avalon side and the NoC side.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   in           : Avalon-ST sink (data/valid/ready/sop/eop/empty)
//   i_dest, i_vc : destination / virtual channel, sampled with sop
//   o_data_out   : flit to NoC (head entry of the buffer)
//   o_valid_out  : flit valid
//   o_ready_in   : NoC accepts the flit this cycle
//   o_pkt_count  : tail flits handed to the NoC (wraps)
//   o_err        : sticky protocol-error flag
module rxr_to_noc_basic #(
    parameter int  DATA_WIDTH = 512,
    parameter int  NOC_WIDTH  = 600,
    parameter int  NUM_VC     = 2,
    parameter int  NOC_RADIX  = 16,
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int DEST_W     = $clog2(NOC_RADIX),
    localparam int EMPTY_W    = $clog2(DATA_WIDTH / 8)
) (
    input  logic                 clk,
    input  logic                 reset,
    avalonST.snk                 in,
    input  logic [DEST_W-1:0]    i_dest,
    input  logic [VC_W-1:0]      i_vc,
    output logic [NOC_WIDTH-1:0] o_data_out,
    output logic                 o_valid_out,
    input  logic                 o_ready_in,
    output logic [31:0]          o_pkt_count,
    output logic                 o_err
);

    localparam int VALID_BIT = NOC_WIDTH - 1;
    localparam int HEAD_BIT  = NOC_WIDTH - 2;
    localparam int TAIL_BIT  = NOC_WIDTH - 3;
    localparam int VC_LSB    = TAIL_BIT - VC_W;
    localparam int DEST_LSB  = VC_LSB - DEST_W;

    if (DATA_WIDTH + EMPTY_W + 3 + VC_W + DEST_W > NOC_WIDTH) begin : g_layout_check
        $error("rxr_to_noc_basic: flit fields do not fit in NOC_WIDTH");
    end

    typedef enum logic {IDLE, BODY} state_t;

    state_t                 state;
    logic [DEST_W-1:0]      pkt_dest;
    logic [VC_W-1:0]        pkt_vc;
    logic                   ready_q;
    logic [1:0]             count;
    logic [1:0]             count_nxt;
    logic [NOC_WIDTH-1:0]   slot0;
    logic [NOC_WIDTH-1:0]   slot1;
    logic [NOC_WIDTH-1:0]   flit;
    logic                   accept;
    logic                   is_head;
    logic                   drop;
    logic                   push;
    logic                   pop;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        accept  = in.valid && ready_q;
        is_head = (state == IDLE) && in.sop;
        // A beat arriving outside a packet without sop has nowhere to go.
        drop    = (state == IDLE) && !in.sop;
        push    = accept && !drop;
        pop     = o_valid_out && o_ready_in;

        flit                        = '0;
        flit[DATA_WIDTH-1:0]        = in.data;
        if (in.eop)
            flit[DATA_WIDTH +: EMPTY_W] = in.empty;
        flit[VALID_BIT]             = 1'b1;
        flit[HEAD_BIT]              = is_head;
        flit[TAIL_BIT]              = in.eop;
        // The sop beat uses the live inputs; later beats use the latched copy.
        flit[VC_LSB +: VC_W]        = is_head ? i_vc : pkt_vc;
        flit[DEST_LSB +: DEST_W]    = is_head ? i_dest : pkt_dest;

        unique case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Packet framing state and error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pkt_dest <= '0;
            pkt_vc   <= '0;
            o_err    <= 1'b0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (in.sop) begin
                        pkt_dest <= i_dest;
                        pkt_vc   <= i_vc;
                        state    <= in.eop ? IDLE : BODY;
                    end else begin
                        o_err <= 1'b1;
                    end
                end
                BODY: begin
                    if (in.sop)
                        o_err <= 1'b1;
                    if (in.eop)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry elastic buffer; slot0 is always the head entry.
    // NOTE: the flit storage is reset because o_data_out must read zero out
    // of reset; a plain FIFO RAM would not need this.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot0       <= '0;
            slot1       <= '0;
            count       <= '0;
            ready_q     <= 1'b0;
            o_pkt_count <= '0;
        end else begin
            if (pop && count == 2'd2)
                slot0 <= slot1;
            else if (push && (count == 2'd0 || (pop && count == 2'd1)))
                slot0 <= flit;

            if (push && !pop && count == 2'd1)
                slot1 <= flit;

            count   <= count_nxt;
            // Registered from the next count: no path from o_ready_in to in.ready.
            ready_q <= (count_nxt < 2'd2);

            if (pop && slot0[TAIL_BIT])
                o_pkt_count <= o_pkt_count + 32'd1;
        end
    end

    assign in.ready    = ready_q;
    assign o_valid_out = (count != 2'd0);
    assign o_data_out  = slot0;

endmodule

// File: tb/tb_rxr_to_noc_basic.sv
// Self-checking bench for rxr_to_noc_basic: table of single-cycle vectors
// plus hand-written backpressure, reset and random-stream sequences.
module tb_rxr_to_noc_basic;

    localparam int DW = 512;
    localparam int NW = 600;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    i_dest;
    logic          i_vc;
    logic [NW-1:0] o_data_out;
    logic          o_valid_out;
    logic          o_ready_in;
    logic [31:0]   o_pkt_count;
    logic          o_err;

    avalonST #(.DATA_WIDTH(DW), .EMPTY_W(6)) av ();

    rxr_to_noc_basic dut (
        .clk         (clk),
        .reset       (reset),
        .in          (av),
        .i_dest      (i_dest),
        .i_vc        (i_vc),
        .o_data_out  (o_data_out),
        .o_valid_out (o_valid_out),
        .o_ready_in  (o_ready_in),
        .o_pkt_count (o_pkt_count),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] got_q[$];
    bit            m_busy;
    logic [3:0]    m_dest;
    logic          m_vc;

    typedef struct {
        logic       valid, sop, eop;
        logic [7:0] dbyte;
        logic [5:0] empty;
        logic [3:0] dest;
        logic       vc;
        logic       exp_valid, exp_head, exp_tail;
        logic [5:0] exp_empty;
        logic [3:0] exp_dest;
        logic       exp_vc;
        logic       exp_err;
        int         exp_pkt;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop, eop;
        logic [5:0]    empty;
        logic [3:0]    dest;
        logic          vc;
    } beat_t;

    function automatic logic [NW-1:0] build_flit(input logic [DW-1:0] d, input logic [5:0] e,
                                                 input logic h, input logic t,
                                                 input logic vc, input logic [3:0] dst);
        logic [NW-1:0] f;
        f          = '0;
        f[511:0]   = d;
        f[517:512] = e;
        f[599]     = 1'b1;
        f[598]     = h;
        f[597]     = t;
        f[596]     = vc;
        f[595:592] = dst;
        return f;
    endfunction

    function automatic vec_t mk(input logic v, input logic s, input logic e, input logic [7:0] b,
                                input logic [5:0] em, input logic [3:0] d, input logic c,
                                input logic xv, input logic xh, input logic xt,
                                input logic [5:0] xe, input logic [3:0] xd, input logic xc,
                                input logic xerr, input int xpkt);
        vec_t r;
        r.valid = v; r.sop = s; r.eop = e; r.dbyte = b; r.empty = em; r.dest = d; r.vc = c;
        r.exp_valid = xv; r.exp_head = xh; r.exp_tail = xt; r.exp_empty = xe;
        r.exp_dest = xd; r.exp_vc = xc; r.exp_err = xerr; r.exp_pkt = xpkt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_flit(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                         input logic [5:0] em, input logic [3:0] dst, input logic c);
        av.valid = v; av.sop = s; av.eop = e; av.data = d; av.empty = em;
        i_dest = dst; i_vc = c;
    endtask

    // Reference behaviour of one accepted beat.
    task automatic model_accept();
        logic h;
        if (!m_busy && !av.sop) return;
        h = !m_busy;
        if (h) begin
            m_dest = i_dest;
            m_vc   = i_vc;
        end
        exp_q.push_back(build_flit(av.data, av.eop ? av.empty : 6'd0, h, av.eop, m_vc, m_dest));
        m_busy = !av.eop;
    endtask

    // Samples handshakes before the edge, then settles just after it.
    task automatic tick(output bit acc);
        @(negedge clk);
        acc = av.valid && av.ready;
        if (reset) begin
            if (o_valid_out && o_ready_in) got_q.push_back(o_data_out);
            if (acc) model_accept();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        m_busy = 1'b0;
        m_dest = '0;
        m_vc   = 1'b0;
    endtask

    task automatic compare_q(input string name);
        int bad;
        bad = 0;
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("FAIL %s_flit[%0d]: got %0h expected %0h", name, i, got_q[i], exp_q[i]);
                bad++;
            end
        end
        check({name, "_order"}, 64'(bad), 64'd0);
    endtask

    vec_t  vecs[13];
    beat_t beats[$];

    initial begin
        bit acc;
        bit done;
        int bi;
        logic [NW-1:0] held;

        //            v  s  e  byte   em d  c  | xv xh xt xe xd xc err pkt
        vecs[0]  = mk(1, 1, 1, 8'hA5, 5, 3, 1,   1, 1, 1, 5, 3, 1, 0, 0);
        vecs[1]  = mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1);
        vecs[2]  = mk(1, 1, 0, 8'h11, 0, 2, 0,   1, 1, 0, 0, 2, 0, 0, 1);
        vecs[3]  = mk(1, 0, 0, 8'h22, 3, 7, 1,   1, 0, 0, 0, 2, 0, 0, 1);
        vecs[4]  = mk(1, 0, 0, 8'h33, 3, 7, 1,   1, 0, 0, 0, 2, 0, 0, 1);
        vecs[5]  = mk(1, 0, 1, 8'h44, 2, 7, 1,   1, 0, 1, 2, 2, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 8'h00, 0, 7, 1,   0, 0, 0, 0, 0, 0, 0, 2);
        vecs[7]  = mk(1, 0, 0, 8'h55, 0, 1, 0,   0, 0, 0, 0, 0, 0, 1, 2);
        vecs[8]  = mk(1, 1, 1, 8'h66, 4, 4, 1,   1, 1, 1, 4, 4, 1, 1, 2);
        vecs[9]  = mk(1, 1, 0, 8'h77, 0, 5, 0,   1, 1, 0, 0, 5, 0, 1, 3);
        vecs[10] = mk(1, 1, 0, 8'h88, 0, 9, 1,   1, 0, 0, 0, 5, 0, 1, 3);
        vecs[11] = mk(1, 0, 1, 8'h99, 1, 9, 1,   1, 0, 1, 1, 5, 0, 1, 3);
        vecs[12] = mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 4);

        clear_model();
        reset      = 1'b0;
        o_ready_in = 1'b0;
        drive(0, 0, 0, '0, 0, 0, 0);

        // Reset state
        repeat (3) tick(acc);
        check("rst_valid", 64'(o_valid_out), 64'd0);
        check("rst_data_zero", 64'(o_data_out == '0), 64'd1);
        check("rst_ready", 64'(av.ready), 64'd0);
        check("rst_pkt", 64'(o_pkt_count), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        reset = 1'b1;
        tick(acc);
        check("post_rst_ready", 64'(av.ready), 64'd1);

        // Table-driven vectors, NoC always ready
        o_ready_in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].valid, vecs[i].sop, vecs[i].eop, {64{vecs[i].dbyte}},
                  vecs[i].empty, vecs[i].dest, vecs[i].vc);
            tick(acc);
            check($sformatf("v%0d_valid", i), 64'(o_valid_out), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check_flit($sformatf("v%0d_flit", i), o_data_out,
                           build_flit({64{vecs[i].dbyte}}, vecs[i].exp_empty, vecs[i].exp_head,
                                      vecs[i].exp_tail, vecs[i].exp_vc, vecs[i].exp_dest));
            check($sformatf("v%0d_err", i), 64'(o_err), 64'(vecs[i].exp_err));
            check($sformatf("v%0d_pkt", i), 64'(o_pkt_count), 64'(vecs[i].exp_pkt));
        end

        // Backpressure: NoC stalled for 5 cycles during a 6-beat packet
        clear_model();
        bi = 0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            if (bi < 6)
                drive(1, bi == 0, bi == 5, {64{8'(8'hB0 + bi)}}, 6'(bi), 4'(6 + bi), 1);
            else
                drive(0, 0, 0, '0, 0, 0, 0);
            o_ready_in = (c >= 5);
            tick(acc);
            if (acc) bi++;
            if (c == 1) begin
                check("bp_accepted_two", 64'(bi), 64'd2);
                check("bp_ready_low", 64'(av.ready), 64'd0);
                held = o_data_out;
            end
            if (c == 4) begin
                check_flit("bp_data_stable", o_data_out, held);
                check("bp_valid_held", 64'(o_valid_out), 64'd1);
            end
        end
        check("bp_all_accepted", 64'(bi), 64'd6);
        compare_q("bp");
        check("bp_pkt", 64'(o_pkt_count), 64'd5);

        // Reset in the middle of a packet
        clear_model();
        o_ready_in = 1'b0;
        drive(1, 1, 0, {64{8'hD1}}, 0, 1, 1);
        tick(acc);
        drive(1, 0, 0, {64{8'hD2}}, 0, 1, 1);
        tick(acc);
        check("mid_two_queued", 64'(o_valid_out), 64'd1);
        reset = 1'b0;
        drive(0, 0, 0, '0, 0, 0, 0);
        tick(acc);
        clear_model();
        check("mid_rst_valid", 64'(o_valid_out), 64'd0);
        check("mid_rst_pkt", 64'(o_pkt_count), 64'd0);
        check("mid_rst_err", 64'(o_err), 64'd0);
        check("mid_rst_ready", 64'(av.ready), 64'd0);
        reset = 1'b1;
        tick(acc);
        check("mid_post_ready", 64'(av.ready), 64'd1);
        o_ready_in = 1'b1;
        drive(1, 1, 1, {64{8'hC3}}, 7, 8, 0);
        tick(acc);
        check_flit("mid_new_pkt", o_data_out, build_flit({64{8'hC3}}, 7, 1, 1, 0, 8));
        drive(0, 0, 0, '0, 0, 0, 0);
        tick(acc);
        check("mid_new_pkt_count", 64'(o_pkt_count), 64'd1);
        check("mid_new_valid", 64'(o_valid_out), 64'd0);

        // 100 random packets with random NoC backpressure
        clear_model();
        for (int p = 0; p < 100; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                beat_t bt;
                for (int w = 0; w < DW / 32; w++) bt.data[w*32 +: 32] = $urandom;
                bt.sop   = (b == 0);
                bt.eop   = (b == len - 1);
                bt.empty = 6'($urandom_range(0, 63));
                bt.dest  = 4'($urandom_range(0, 15));
                bt.vc    = 1'($urandom_range(0, 1));
                beats.push_back(bt);
            end
        end
        bi = 0;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            if (bi < beats.size() && $urandom_range(0, 3) != 0)
                drive(1, beats[bi].sop, beats[bi].eop, beats[bi].data, beats[bi].empty,
                      beats[bi].dest, beats[bi].vc);
            else
                drive(0, 0, 0, '0, 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            o_ready_in = 1'($urandom_range(0, 1));
            tick(acc);
            if (acc) bi++;
            done = (bi == beats.size()) && !o_valid_out;
        end
        check("rand_done_in_budget", 64'(done), 64'd1);
        compare_q("rand");
        check("rand_pkt", 64'(o_pkt_count), 64'd101);
        check("rand_err", 64'(o_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rxr_to_noc_basic.md
# rxr_to_noc_basic

Ingress bridge from a receiver-side Avalon-ST packet stream into NoC flits. Each accepted beat becomes one flit carrying the 512-bit payload plus head/tail/empty/VC/destination fields in the layout the NoC egress translator unpacks. Destination and VC are sampled per packet. A two-entry elastic buffer decouples Avalon backpressure from NoC backpressure at full throughput.

## Interface
- DATA_WIDTH, 512, Avalon-ST payload width in bits.
- NOC_WIDTH, 600, NoC flit width.
- NUM_VC, 2, virtual channels; VC_W = max(1, $clog2(NUM_VC)).
- NOC_RADIX, 16, NoC endpoints; DEST_W = $clog2(NOC_RADIX).
- EMPTY_W, derived, $clog2(DATA_WIDTH/8) = 6.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in  avalonST.snk  —  sink modport: data[DATA_WIDTH-1:0], valid, ready, sop, eop, empty[EMPTY_W-1:0].
- i_dest  in  DEST_W  destination router, sampled with the sop beat.
- i_vc  in  VC_W  virtual channel, sampled with the sop beat.
- o_data_out  out  NOC_WIDTH  flit to NoC.
- o_valid_out  out  1  flit valid.
- o_ready_in  in  1  NoC can accept a flit.
- o_pkt_count  out  32  packets (tail flits) delivered to NoC.
- o_err  out  1  sticky protocol-error flag.

## Operation
- Flit layout: [DATA_WIDTH-1:0] data; [DATA_WIDTH+EMPTY_W-1:DATA_WIDTH] empty; [NOC_WIDTH-1] valid; [NOC_WIDTH-2] head (=sop); [NOC_WIDTH-3] tail (=eop); next VC_W bits down: VC; next DEST_W bits down: dest; all other bits 0. Elaboration error if DATA_WIDTH+EMPTY_W+3+VC_W+DEST_W > NOC_WIDTH.
- Beat accepted when in.valid && in.ready.
- Packet FSM, states IDLE, BODY:
  - IDLE, accepted beat with sop: latch i_dest/i_vc into packet registers, emit flit head=1. eop also set → single-flit packet, head=tail=1, stay IDLE; else → BODY.
  - IDLE, accepted beat without sop: beat dropped (not written to buffer), o_err set.
  - BODY, accepted beat: flit uses latched dest/VC, head=0. eop → tail=1, → IDLE.
  - BODY, sop asserted again: sop ignored (head=0), beat treated as body, o_err set.
- empty is forwarded only on tail flits; forced 0 on non-tail flits.
- Elastic buffer: 2-entry FIFO of formatted flits; head entry drives o_data_out/o_valid_out.
- in.ready = FIFO count < 2 (registered from count; no combinational path from o_ready_in).
- o_pkt_count increments by 1 on each NoC transfer (o_valid_out && o_ready_in) of a tail flit; wraps 2^32-1 → 0.
- o_err clears only on reset.

## Timing
- Reset (reset==0 at a clk edge): FIFO emptied, FSM → IDLE, o_valid_out=0, o_data_out=0, in.ready=0, o_pkt_count=0, o_err=0. in.ready=1 in the first cycle after reset deasserts.
- Reset mid-packet: partial packet discarded; no tail generated.
- Latency: beat accepted at edge N is on o_data_out with o_valid_out=1 after edge N (registered), earliest transfer at edge N+1.
- Throughput: one flit/cycle sustained while o_ready_in=1.
- o_valid_out && !o_ready_in: o_data_out held stable until transfer.
- Simultaneous accept and NoC pop at count=2 impossible (in.ready=0); at count=1 both occur and count stays 1.
- FIFO full (count=2): in.ready=0 next cycle; dropped beats in IDLE still consume an in.ready cycle but never enter FIFO.

## Test plan
- Single-flit packet: sop=eop=1, data=0xA5.., empty=5, i_dest=3, i_vc=1, o_ready_in=1 → one flit next cycle, head=tail=1, empty=5, dest=3, VC=1; o_pkt_count=1.
- 4-beat packet, i_dest changes to 7 after sop (was 2) → all 4 flits dest=2; head only on first, tail only on fourth; empty=0 on flits 1–3.
- Backpressure: o_ready_in=0 for 5 cycles during 6-beat stream → in.ready falls after 2 beats accepted, o_data_out stable, all 6 flits delivered in order, none lost or duplicated.
- Protocol errors: beat without sop in IDLE → no flit, o_err=1; sop mid-packet → flit head=0, o_err stays 1.
- Reset mid-packet after 2 beats → o_valid_out=0, count 0; next sop packet delivered correctly with head=1.
- Back-to-back 100 random-length packets, o_ready_in random 50% → o_pkt_count=100, flit stream matches scoreboard.
